// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one valid/ready output channel
// among four requesters. A 4:1 mux steers the granted lane's data to Out and
// a 1:4 demux returns the transfer strobe to the granted lane as Ack.
module mux_rr_arbiter #(
  parameter int W     = 1,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Enable,
  input  logic [3:0]     Req,
  input  logic [4*W-1:0] In,
  input  logic           Out_ready,
  output logic [3:0]     Gnt,
  output logic [1:0]     Sel,
  output logic           Busy,
  output logic [W-1:0]   Out,
  output logic           Out_valid,
  output logic [3:0]     Ack
);

  // Beat counter needs at least one bit so BURST = 1 still elaborates.
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       sel_reg, sel_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       gnt_reg, gnt_next;

  logic [W-1:0]     lane_data [4];
  logic [1:0]       rot_idx   [4];
  logic [3:0]       rot_req;
  logic             found;
  logic [1:0]       winner;
  logic             busy;
  logic             xfer;
  logic             burst_end;

  // Per-lane slicing, request rotation relative to ptr, and the Ack demux.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_data[gi] = In[gi*W +: W];
      assign rot_idx[gi]   = ptr_reg + 2'(gi);
      assign rot_req[gi]   = Req[rot_idx[gi]];
      assign Ack[gi]       = xfer && (sel_reg == 2'(gi));
    end
  endgenerate

  // Winner is the first requesting lane at or after ptr (searched mod 4).
  always_comb begin
    found  = 1'b0;
    winner = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) begin
        found  = 1'b1;
        winner = rot_idx[k];
      end
    end
  end

  assign busy      = (state_reg == BUSY);
  assign Out_valid = busy && Req[sel_reg];
  assign xfer      = Out_valid && Out_ready;
  assign Out       = busy ? lane_data[sel_reg] : '0;
  // A burst closes on its last accepted beat or when the grantee withdraws.
  assign burst_end = busy && (!Req[sel_reg] || (xfer && (cnt_reg == CNT_LAST)));

  assign Gnt  = gnt_reg;
  assign Sel  = sel_reg;
  assign Busy = busy;

  // Next-state logic: arbitrate in IDLE, count beats and close bursts in BUSY.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    case (state_reg)
      IDLE: begin
        if (Enable && found) begin
          state_next = BUSY;
          sel_next   = winner;
          gnt_next   = 4'b0001 << winner;
          cnt_next   = '0;
        end
      end
      BUSY: begin
        if (burst_end) begin
          state_next = IDLE;
          gnt_next   = 4'b0000;
          ptr_next   = sel_reg + 2'd1;
          cnt_next   = '0;
        end else if (xfer) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any partial burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      sel_reg   <= 2'd0;
      cnt_reg   <= '0;
      gnt_reg   <= 4'b0000;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_mux_rr_arbiter;

  localparam int W     = 8;
  localparam int BURST = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           Enable;
  logic [3:0]     Req;
  logic [4*W-1:0] In;
  logic           Out_ready;
  logic [3:0]     Gnt;
  logic [1:0]     Sel;
  logic           Busy;
  logic [W-1:0]   Out;
  logic           Out_valid;
  logic [3:0]     Ack;

  mux_rr_arbiter #(.W(W), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .Enable(Enable), .Req(Req), .In(In),
    .Out_ready(Out_ready), .Gnt(Gnt), .Sel(Sel), .Busy(Busy),
    .Out(Out), .Out_valid(Out_valid), .Ack(Ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: who holds the channel, where the search starts next,
  // and how many beats the current grantee has delivered.
  int m_busy  = 0;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_beats = 0;

  // Values observed in the most recent step, for directed checks.
  logic [3:0] s_gnt;
  logic [3:0] s_ack;
  logic       s_busy;
  logic       prev_busy = 1'b0;
  int         grants[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_end_burst();
    m_busy  = 0;
    m_ptr   = (m_sel + 1) % 4;
    m_beats = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then
  // advance the model across the rising edge using the same inputs.
  task automatic step(input logic r, input logic en, input logic [3:0] rq, input logic rdy);
    int exp_gnt, exp_ack, exp_valid, exp_out;
    @(negedge clk);
    rst = r; Enable = en; Req = rq; Out_ready = rdy; In = $urandom();
    #1;
    exp_valid = (m_busy != 0 && rq[m_sel]) ? 1 : 0;
    exp_gnt   = (m_busy != 0) ? (1 << m_sel) : 0;
    exp_ack   = (exp_valid != 0 && rdy) ? (1 << m_sel) : 0;
    exp_out   = (m_busy != 0) ? int'((In >> (W * m_sel)) & 32'hFF) : 0;
    check("gnt",   32'(Gnt),       32'(exp_gnt));
    check("sel",   32'(Sel),       32'(m_sel));
    check("busy",  32'(Busy),      32'(m_busy));
    check("valid", 32'(Out_valid), 32'(exp_valid));
    check("ack",   32'(Ack),       32'(exp_ack));
    check("out",   32'(Out),       32'(exp_out));
    s_gnt = Gnt; s_ack = Ack; s_busy = Busy;
    if (Busy && !prev_busy) grants.push_back(int'(Sel));
    prev_busy = Busy;
    $display("cyc rst=%b en=%b req=%b rdy=%b | gnt=%b sel=%0d busy=%b valid=%b ack=%b out=%h",
             r, en, rq, rdy, Gnt, Sel, Busy, Out_valid, Ack, Out);
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
    end else if (m_busy == 0) begin
      if (en && rq != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          int lane;
          lane = (m_ptr + k) % 4;
          if (rq[lane]) begin
            m_busy = 1; m_sel = lane; m_beats = 0;
            break;
          end
        end
      end
    end else if (!rq[m_sel]) begin
      model_end_burst();
    end else if (rdy) begin
      m_beats++;
      if (m_beats == BURST) model_end_burst();
    end
  endtask

  initial begin
    int acks, busy_cyc, n;
    logic [3:0] rq;
    rst = 1'b1; Enable = 1'b0; Req = 4'b1111; Out_ready = 1'b0; In = '0;
    repeat (2) @(posedge clk);

    // Reset held with all lanes requesting, then first grant goes to lane 0.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 4'b1111, 1'b1);
      check("rst_gnt", 32'(s_gnt), 32'h0);
      check("rst_ack", 32'(s_ack), 32'h0);
    end
    grants.delete();
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    check("first_gnt", 32'(s_gnt), 32'h1);

    // Round-robin with everyone requesting: order 0,1,2,3,0.
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 4'b1111, 1'b1);
    check("rr_count", 32'(grants.size() >= 5), 32'h1);
    n = (grants.size() < 5) ? grants.size() : 5;
    for (int i = 0; i < n; i++) check("rr_order", 32'(grants[i]), 32'(i % 4));

    // Backpressure on lane 2 with Out_ready alternating.
    step(1'b0, 1'b1, 4'b0000, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 1'b1);
    acks = 0; busy_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 4'b0100, (i % 2) == 0);
      if (s_ack == 4'b0100) acks++;
      if (s_busy) busy_cyc++;
    end
    check("bp_acks", 32'(acks), 32'd4);
    check("bp_busy", 32'(busy_cyc), 32'd8);

    // Enable gating: no grant while low, a started burst always completes.
    step(1'b0, 1'b1, 4'b0000, 1'b1);
    busy_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 4'b0100, 1'b1);
      if (s_busy) busy_cyc++;
    end
    check("en_nogrant", 32'(busy_cyc), 32'd0);
    step(1'b0, 1'b1, 4'b0100, 1'b1);
    acks = 0; busy_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 4'b0100, 1'b1);
      if (i == 0) check("en_gnt", 32'(s_gnt), 32'h4);
      if (s_ack == 4'b0100) acks++;
      if (s_busy) busy_cyc++;
    end
    check("en_acks", 32'(acks), 32'd4);
    check("en_busy", 32'(busy_cyc), 32'd4);

    // Early withdrawal of lane 1 moves ptr to 2, so lane 3 wins next.
    step(1'b0, 1'b1, 4'b0010, 1'b1);
    step(1'b0, 1'b1, 4'b0010, 1'b1);
    step(1'b0, 1'b1, 4'b0010, 1'b1);
    step(1'b0, 1'b1, 4'b1001, 1'b1);
    check("wd_busy", 32'(s_busy), 32'h1);
    step(1'b0, 1'b1, 4'b1011, 1'b1);
    check("wd_idle", 32'(s_busy), 32'h0);
    step(1'b0, 1'b1, 4'b1011, 1'b1);
    check("wd_gnt", 32'(s_gnt), 32'h8);

    // Reset in the middle of a lane 0 burst.
    step(1'b0, 1'b1, 4'b0000, 1'b1);
    step(1'b0, 1'b1, 4'b0001, 1'b1);
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    step(1'b1, 1'b1, 4'b1111, 1'b1);
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    check("mr_gnt", 32'(s_gnt), 32'h0);
    check("mr_ack", 32'(s_ack), 32'h0);
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    check("mr_regnt", 32'(s_gnt), 32'h1);

    // Random traffic: sticky requests, occasional reset, Enable and ready noise.
    rq = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(99) < 15) rq[b] = ~rq[b];
      step($urandom_range(99) < 1, $urandom_range(99) < 85, rq, $urandom_range(99) < 70);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
